// File: rtl/sweep_ctrl.sv
// Frequency-sweep (chirp) controller driving the DDS frequency word.
// Optional triangle (up then down) sweep: define SWEEP_CTRL_TRIANGLE_EN.
module sweep_ctrl #(
    parameter int PW  = 32,
    parameter int DWW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [PW-1:0] fStart,
    input  logic signed [PW-1:0] fStop,
    input  logic        [PW-1:0] fStep,
    input  logic       [DWW-1:0] dwell,
    output logic signed [PW-1:0] freq,
    output logic                 busy,
    output logic                 done,
    output logic                 stepStb
);

`ifdef SWEEP_CTRL_TRIANGLE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1
    } state_t;
`endif

    state_t                state_q;
    logic signed [PW-1:0]  freq_q;
    logic signed [PW-1:0]  stop_q;
    logic        [PW-1:0]  step_q;
    logic       [DWW-1:0]  dwell_q;
    logic       [DWW-1:0]  cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  stb_q;

    logic signed [PW:0]    up_sum;
    logic signed [PW:0]    stop_ext;
    logic signed [PW-1:0]  freq_up_d;
    logic                  dwell_done;
    logic                  at_stop;

    // One bit of headroom keeps freq+step from wrapping before the clamp.
    always_comb begin
        stop_ext   = $signed({stop_q[PW-1], stop_q});
        up_sum     = $signed({freq_q[PW-1], freq_q}) + $signed({1'b0, step_q});
        freq_up_d  = (up_sum >= stop_ext) ? stop_q : up_sum[PW-1:0];
        dwell_done = (cnt_q == dwell_q);
        at_stop    = (freq_q >= stop_q);
    end

`ifdef SWEEP_CTRL_TRIANGLE_EN
    logic signed [PW-1:0]  start_q;
    logic signed [PW:0]    dn_sum;
    logic signed [PW:0]    start_ext;
    logic signed [PW-1:0]  freq_dn_d;
    logic                  at_start;

    always_comb begin
        start_ext = $signed({start_q[PW-1], start_q});
        dn_sum    = $signed({freq_q[PW-1], freq_q}) - $signed({1'b0, step_q});
        freq_dn_d = (dn_sum <= start_ext) ? start_q : dn_sum[PW-1:0];
        at_start  = (freq_q <= start_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
`ifdef SWEEP_CTRL_TRIANGLE_EN
            start_q <= '0;
`endif
        end else if (en) begin
            done_q <= 1'b0;
            stb_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        stop_q  <= fStop;
                        step_q  <= (fStep == '0) ? PW'(1) : fStep;
                        dwell_q <= dwell;
                        freq_q  <= fStart;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= UP;
`ifdef SWEEP_CTRL_TRIANGLE_EN
                        start_q <= fStart;
`endif
                    end
                end
                UP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!dwell_done) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!at_stop) begin
                            freq_q <= freq_up_d;
                            stb_q  <= 1'b1;
                        end else begin
`ifdef SWEEP_CTRL_TRIANGLE_EN
                            // A degenerate sweep (start >= stop) has nothing to descend.
                            if (start_q < stop_q) begin
                                state_q <= DOWN;
                                freq_q  <= freq_dn_d;
                                stb_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SWEEP_CTRL_TRIANGLE_EN
                DOWN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!dwell_done) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!at_start) begin
                            freq_q <= freq_dn_d;
                            stb_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pulses survive an en=0 stall and show on the next enabled cycle.
    assign freq    = freq_q;
    assign busy    = busy_q;
    assign done    = done_q & en;
    assign stepStb = stb_q & en;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: vector table, hand sequences, random sweeps.
module tb_sweep_ctrl;
    localparam int PW  = 32;
    localparam int DWW = 16;

    logic           clk = 1'b0;
    logic           rst_n, en, start, abort;
    logic [PW-1:0]  fStart, fStop, fStep, freq;
    logic [DWW-1:0] dwell;
    logic           busy, done, stepStb;

    int n_tests = 0;
    int n_fail  = 0;
    longint flist[$];

    always #5 clk = ~clk;

    sweep_ctrl #(.PW(PW), .DWW(DWW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
        .fStart(fStart), .fStop(fStop), .fStep(fStep), .dwell(dwell),
        .freq(freq), .busy(busy), .done(done), .stepStb(stepStb)
    );

    typedef struct {
        logic [PW-1:0]  s, e, st;
        logic [DWW-1:0] dw;
        int             exp_pulses;
        logic [PW-1:0]  exp_last;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [PW-1:0] ef,
                           input logic eb, input logic es, input logic ed);
        #1;
        n_tests++;
        if (freq !== ef || busy !== eb || stepStb !== es || done !== ed) begin
            n_fail++;
            $display("FAIL %s: got freq=%h busy=%b stb=%b done=%b, expected freq=%h busy=%b stb=%b done=%b",
                     nm, freq, busy, stepStb, done, ef, eb, es, ed);
        end
    endtask

    // Reference list of frequencies visited by a sweep, from plain integer arithmetic.
    function automatic void build(input longint s, input longint e, input longint st);
        longint f;
        flist.delete();
        if (st == 0) st = 1;
        f = s;
        flist.push_back(f);
        if (s < e) begin
            while (f < e) begin
                f = f + st;
                if (f > e) f = e;
                flist.push_back(f);
            end
`ifdef SWEEP_CTRL_TRIANGLE_EN
            while (f > s) begin
                f = f - st;
                if (f < s) f = s;
                flist.push_back(f);
            end
`endif
        end
    endfunction

    task automatic run_sweep(input logic [PW-1:0] s, input logic [PW-1:0] e,
                             input logic [PW-1:0] st, input logic [DWW-1:0] dw,
                             input int stall_at, input int stall_len,
                             output int pulses, output int busyc, output logic [PW-1:0] last);
        longint fv;
        logic [PW-1:0] ef;
        int k;
        build(longint'($signed(s)), longint'($signed(e)), longint'(st));
        fStart = s; fStop = e; fStep = st; dwell = dw;
        en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        fStart = $urandom; fStop = $urandom; fStep = $urandom; dwell = DWW'($urandom);
        pulses = 0; busyc = 0; k = 0; ef = '0;
        for (int i = 0; i < flist.size(); i++) begin
            fv = flist[i];
            ef = fv[PW-1:0];
            for (int j = 0; j <= int'(dw); j++) begin
                if (k == stall_at && stall_len > 0) begin
                    en = 1'b0;
                    for (int m = 0; m < stall_len; m++) begin
                        chk_out("stall", ef, 1'b1, 1'b0, 1'b0);
                        if (stepStb) pulses++;
                        if (busy) busyc++;
                        tick();
                    end
                    en = 1'b1;
                end
                chk_out("trace", ef, 1'b1, (j == 0), 1'b0);
                if (stepStb) pulses++;
                if (busy) busyc++;
                k++;
                tick();
            end
        end
        chk_out("done_cycle", ef, 1'b0, 1'b0, 1'b1);
        last = freq;
        tick();
        chk_out("after_done", ef, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t vecs[8];
        int pulses, busyc;
        logic [PW-1:0] last;
        logic [PW-1:0] rs, re, rst;
        logic [DWW-1:0] rdw;

`ifdef SWEEP_CTRL_TRIANGLE_EN
        vecs[0] = '{32'd100, 32'd130, 32'd10, 16'd2, 7, 32'd100};
        vecs[1] = '{32'd0, 32'd25, 32'd10, 16'd0, 7, 32'd0};
        vecs[2] = '{32'h7FFFFFF0, 32'h7FFFFFFF, 32'h20, 16'd0, 3, 32'h7FFFFFF0};
        vecs[3] = '{32'd50, 32'd50, 32'd7, 16'd3, 1, 32'd50};
        vecs[4] = '{32'd200, 32'd100, 32'd5, 16'd1, 1, 32'd200};
        vecs[5] = '{32'h80000005, 32'h80000032, 32'h40000000, 16'd1, 3, 32'h80000005};
        vecs[6] = '{32'd10, 32'd13, 32'd0, 16'd0, 7, 32'd10};
        vecs[7] = '{32'hFFFFFFEC, 32'd20, 32'd15, 16'd1, 7, 32'hFFFFFFEC};
`else
        vecs[0] = '{32'd100, 32'd130, 32'd10, 16'd2, 4, 32'd130};
        vecs[1] = '{32'd0, 32'd25, 32'd10, 16'd0, 4, 32'd25};
        vecs[2] = '{32'h7FFFFFF0, 32'h7FFFFFFF, 32'h20, 16'd0, 2, 32'h7FFFFFFF};
        vecs[3] = '{32'd50, 32'd50, 32'd7, 16'd3, 1, 32'd50};
        vecs[4] = '{32'd200, 32'd100, 32'd5, 16'd1, 1, 32'd200};
        vecs[5] = '{32'h80000005, 32'h80000032, 32'h40000000, 16'd1, 2, 32'h80000032};
        vecs[6] = '{32'd10, 32'd13, 32'd0, 16'd0, 4, 32'd13};
        vecs[7] = '{32'hFFFFFFEC, 32'd20, 32'd15, 16'd1, 4, 32'd20};
`endif

        rst_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
        fStart = '0; fStop = '0; fStep = '0; dwell = '0;
        tick(); tick();
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", '0, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 8; v++) begin
            run_sweep(vecs[v].s, vecs[v].e, vecs[v].st, vecs[v].dw, -1, 0, pulses, busyc, last);
            chk_val($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
            chk_val($sformatf("vec%0d_busy", v), busyc, vecs[v].exp_pulses * (int'(vecs[v].dw) + 1));
            chk_val($sformatf("vec%0d_last", v), longint'(last), longint'(vecs[v].exp_last));
        end

        // Basic sweep with a 5-cycle en=0 stall at the start of the 120 dwell.
        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 6, 5, pulses, busyc, last);
`ifdef SWEEP_CTRL_TRIANGLE_EN
        chk_val("stall_pulses", pulses, 7);
        chk_val("stall_busy", busyc, 26);
`else
        chk_val("stall_pulses", pulses, 4);
        chk_val("stall_busy", busyc, 17);
`endif

        // Abort at 110; en=0 abort ignored, then abort with a simultaneous start.
        fStart = 32'd100; fStop = 32'd130; fStep = 32'd10; dwell = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("abort_first", 32'd100, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk_out("abort_at_110", 32'd110, 1'b1, 1'b1, 1'b0);
        en = 1'b0; abort = 1'b1;
        tick();
        chk_out("abort_en_low", 32'd110, 1'b1, 1'b0, 1'b0);
        en = 1'b1; start = 1'b1; fStart = 32'd999;
        tick();
        chk_out("abort_idle", 32'd110, 1'b0, 1'b0, 1'b0);
        start = 1'b0; abort = 1'b0;
        tick(); tick();
        chk_out("abort_hold", 32'd110, 1'b0, 1'b0, 1'b0);
        start = 1'b1; abort = 1'b1;
        tick();
        chk_out("start_with_abort", 32'd110, 1'b0, 1'b0, 1'b0);
        start = 1'b0; abort = 1'b0;

        // Reset in the middle of a sweep.
        fStart = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk_out("pre_reset", 32'd110, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("mid_reset", '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); tick();
        chk_out("post_reset_idle", '0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            if (r % 6 == 0) begin
                rs  = 32'h7FFFFF00 + $urandom_range(0, 200);
                re  = 32'h7FFFFFFF;
                rst = 32'h10000000 + $urandom_range(0, 1000);
            end else if (r % 6 == 3) begin
                rs  = 32'h80000000 + $urandom_range(0, 50);
                re  = rs + $urandom_range(0, 100);
                rst = 32'h40000000 + $urandom_range(0, 1000);
            end else begin
                rs  = $urandom_range(0, 400) - 200;
                re  = rs + $urandom_range(0, 300) - 50;
                rst = $urandom_range(0, 40);
            end
            rdw = DWW'($urandom_range(0, 3));
            run_sweep(rs, re, rst, rdw, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                      pulses, busyc, last);
            chk_val($sformatf("rand%0d_pulses", r), pulses, flist.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
